// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: load-use and mult/div structural stalls, branch flush,
// MD unit occupancy tracking and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_IsMD,
  input  logic        ID_ReadsHiLo,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [15:0] StallCount
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] MdLoad = 5'(MD_LATENCY - 1);

  state_t      state;
  state_t      stateNxt;
  logic [4:0]  mdCnt;
  logic [4:0]  mdCntNxt;
  logic        mdStartQ;
  logic [15:0] stallCnt;

  logic loadUse;
  logic mdHazard;
  logic stall;
  logic flush;
  logic accept;

  // Register 0 is compared like any other register.
  assign loadUse = EX_MemRead &&
    ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  assign mdHazard = (state == MD_BUSY) &&
    (ID_IsMD || ID_ReadsHiLo);

  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    accept = 1'b0;
    priority case (1'b1)
      rst:            ;
      EX_BranchTaken: flush = 1'b1;
      loadUse,
      mdHazard:       stall = 1'b1;
      (state == RUN) && ID_IsMD:
                      accept = 1'b1;
      default:        ;
    endcase
  end

  assign PCWrite     = !stall;
  assign IFID_Write  = !stall;
  assign IDEX_Bubble = stall;
  assign IFID_Flush  = flush;
  assign IDEX_Flush  = flush;
  assign MD_Start    = mdStartQ;
  assign MD_Busy     = (state == MD_BUSY);
  assign StallCount  = stallCnt;

  // An in-flight MD op is older than any branch, so flush never stops it.
  always_comb begin
    stateNxt = state;
    mdCntNxt = mdCnt;
    case (state)
      RUN: begin
        if (accept) begin
          stateNxt = MD_BUSY;
          mdCntNxt = MdLoad;
        end
      end
      MD_BUSY: begin
        if (mdCnt != 5'd0) begin
          mdCntNxt = mdCnt - 5'd1;
        end else begin
          stateNxt = RUN;
        end
      end
      default: stateNxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      mdCnt    <= 5'd0;
      mdStartQ <= 1'b0;
      stallCnt <= 16'd0;
    end else begin
      state    <= stateNxt;
      mdCnt    <= mdCntNxt;
      mdStartQ <= accept;
      if (stall && (stallCnt != 16'hFFFF)) begin
        stallCnt <= stallCnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed test-plan scenarios plus
// random stimulus checked every cycle against a cycle-count model.
module tb_pipeline_hazard_controller;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ID_Rs = '0;
  logic [4:0]  ID_Rt = '0;
  logic        ID_UsesRt = 1'b0;
  logic        ID_IsMD = 1'b0;
  logic        ID_ReadsHiLo = 1'b0;
  logic        EX_MemRead = 1'b0;
  logic [4:0]  EX_Rt = '0;
  logic        EX_BranchTaken = 1'b0;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IDEX_Bubble;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        MD_Start;
  logic        MD_Busy;
  logic [15:0] StallCount;

  pipeline_hazard_controller #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_IsMD(ID_IsMD),
    .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: remaining busy cycles, last-cycle launch, stall total.
  int mBusyLeft = 0;
  bit mStart = 0;
  int mStalls = 0;
  bit chkEn = 0;

  function automatic bit mFlush();
    return !rst && EX_BranchTaken;
  endfunction

  function automatic bit mStall();
    bit lu;
    bit md;
    lu = EX_MemRead && (EX_Rt == ID_Rs ||
         (ID_UsesRt && EX_Rt == ID_Rt));
    md = (mBusyLeft > 0) && (ID_IsMD || ID_ReadsHiLo);
    return !rst && !EX_BranchTaken && (lu || md);
  endfunction

  function automatic bit mAccept();
    return !rst && !EX_BranchTaken && !mStall() &&
           mBusyLeft == 0 && ID_IsMD;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mBusyLeft = 0;
      mStart = 0;
      mStalls = 0;
      chkEn = 1;
    end else begin
      bit acc;
      acc = mAccept();
      if (mStall() && mStalls < 65535) mStalls++;
      mStart = acc;
      if (acc) mBusyLeft = LAT;
      else if (mBusyLeft > 0) mBusyLeft--;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("PCWrite", int'(PCWrite), int'(!mStall()));
      chk("IFID_Write", int'(IFID_Write), int'(!mStall()));
      chk("IDEX_Bubble", int'(IDEX_Bubble), int'(mStall()));
      chk("IFID_Flush", int'(IFID_Flush), int'(mFlush()));
      chk("IDEX_Flush", int'(IDEX_Flush), int'(mFlush()));
      chk("MD_Start", int'(MD_Start), int'(mStart));
      chk("MD_Busy", int'(MD_Busy), int'(mBusyLeft > 0));
      chk("StallCount", int'(StallCount), mStalls);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Rs = 5'd9; ID_Rt = 5'd10; ID_UsesRt = 0;
    ID_IsMD = 0; ID_ReadsHiLo = 0;
    EX_MemRead = 0; EX_Rt = 5'd11; EX_BranchTaken = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    EX_BranchTaken = 1;
    #2;
    chk("rst_force_flush", int'(IFID_Flush), 0);
    chk("rst_force_pc", int'(PCWrite), 1);
    cyc();
    cyc();
    rst = 0;
    idle();
    #2;
    chk("reset_stallcount", int'(StallCount), 0);
    chk("reset_busy", int'(MD_Busy), 0);

    // Load-use on rs.
    EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
    #1;
    chk("lu_pcwrite", int'(PCWrite), 0);
    chk("lu_ifid", int'(IFID_Write), 0);
    chk("lu_bubble", int'(IDEX_Bubble), 1);
    cyc();
    chk("lu_count", int'(StallCount), 1);

    // Register 0 hazard through rt, only when rt is a source.
    ID_Rs = 9; EX_Rt = 0; ID_Rt = 0; ID_UsesRt = 1;
    #1;
    chk("r0_stall", int'(IDEX_Bubble), 1);
    ID_UsesRt = 0;
    #1;
    chk("r0_nouse", int'(PCWrite), 1);
    cyc();
    idle();

    // mult accepted at T, mfhi waits in ID.
    ID_IsMD = 1;
    #1;
    chk("mult_accept_pc", int'(PCWrite), 1);
    cyc();
    ID_IsMD = 0; ID_ReadsHiLo = 1;
    #1;
    chk("md_start_t1", int'(MD_Start), 1);
    chk("md_busy_t1", int'(MD_Busy), 1);
    chk("mfhi_stall_t1", int'(PCWrite), 0);
    for (int k = 2; k <= LAT; k++) begin
      cyc();
      chk("md_start_off", int'(MD_Start), 0);
      chk("md_busy_on", int'(MD_Busy), 1);
      chk("mfhi_stall", int'(PCWrite), 0);
    end
    cyc();
    chk("md_busy_end", int'(MD_Busy), 0);
    chk("mfhi_issue", int'(PCWrite), 1);
    chk("mfhi_count", int'(StallCount), 5);
    idle();

    // Flush while busy, then reset mid-operation.
    ID_IsMD = 1;
    cyc();
    EX_BranchTaken = 1;
    #1;
    chk("fl_ifid", int'(IFID_Flush), 1);
    chk("fl_idex", int'(IDEX_Flush), 1);
    chk("fl_pc", int'(PCWrite), 1);
    chk("fl_busy", int'(MD_Busy), 1);
    cyc();
    idle();
    chk("fl_busy_t2", int'(MD_Busy), 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("rst_mid_busy", int'(MD_Busy), 0);
    chk("rst_mid_count", int'(StallCount), 0);
    ID_IsMD = 1;
    cyc();
    ID_IsMD = 0;
    chk("reaccept_start", int'(MD_Start), 1);
    chk("reaccept_busy", int'(MD_Busy), 1);
    repeat (LAT + 1) cyc();

    // Flush with mult in ID while running: no accept.
    EX_BranchTaken = 1; ID_IsMD = 1;
    cyc();
    idle();
    chk("fl_noaccept_start", int'(MD_Start), 0);
    chk("fl_noaccept_busy", int'(MD_Busy), 0);

    // Randomised traffic; small register range forces collisions.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      EX_Rt = 5'($urandom_range(0, 3));
      ID_UsesRt = 1'($urandom);
      EX_MemRead = ($urandom_range(0, 3) == 0);
      EX_BranchTaken = ($urandom_range(0, 7) == 0);
      ID_IsMD = ($urandom_range(0, 2) == 0);
      ID_ReadsHiLo = ($urandom_range(0, 3) == 0);
      cyc();
    end

    // Saturation.
    idle();
    rst = 1;
    cyc();
    rst = 0;
    EX_MemRead = 1; EX_Rt = 7; ID_Rs = 7;
    repeat (70000) cyc();
    chk("sat_count", int'(StallCount), 16'hFFFF);
    chk("sat_stall", int'(PCWrite), 0);
    idle();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
